// File: rtl/key_schedule_ctrl.sv
// AES-128 key-schedule sequencer: steps an external expander through rounds 0..10,
// captures each round key into an 11-entry store and serves them over a registered read port.
module key_schedule_ctrl #(
  parameter int EXP_LAT = 2,
  parameter int NUM_RK  = 11,
  parameter int KEY_W   = 128
) (
  input  logic             pi_clk,
  input  logic             pi_rst,
  input  logic             pi_key_valid,
  input  logic [KEY_W-1:0] pi_key,
  output logic             po_key_ready,
  output logic [KEY_W-1:0] po_exp_key,
  output logic [3:0]       po_exp_round,
  output logic             po_exp_update,
  input  logic [KEY_W-1:0] pi_exp_key,
  output logic             po_busy,
  output logic             po_done,
  output logic             po_keys_valid,
  input  logic             pi_rk_req,
  input  logic [3:0]       pi_rk_idx,
  output logic             po_rk_valid,
  output logic [KEY_W-1:0] po_rk_data,
  output logic             po_rk_err,
  output logic [2:0]       po_dbg_state
);

  // Key handshake: a key transfers on any rising edge where pi_key_valid && po_key_ready;
  // po_key_ready is registered and only high in IDLE/READY, so offers while busy are dropped.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STEP  = 3'd1,
    S_WAIT  = 3'd2,
    S_CAPT  = 3'd3,
    S_READY = 3'd4
  } state_t;

  localparam logic [3:0] LAST_RK = 4'(NUM_RK - 1);
  localparam int CNT_W = (EXP_LAT > 1) ? $clog2(EXP_LAT) : 1;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(EXP_LAT - 1);

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic [KEY_W-1:0]   store [NUM_RK];
  logic               accept;

  assign accept       = pi_key_valid && po_key_ready;
  assign po_dbg_state = state;

  // po_exp_round doubles as the round counter; it only ever advances from CAPT below LAST_RK.
  always_ff @(posedge pi_clk or posedge pi_rst) begin
    if (pi_rst) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      po_key_ready  <= 1'b0;
      po_exp_key    <= '0;
      po_exp_round  <= '0;
      po_exp_update <= 1'b0;
      po_busy       <= 1'b0;
      po_done       <= 1'b0;
      po_keys_valid <= 1'b0;
      for (int i = 0; i < NUM_RK; i++) store[i] <= '0;
    end else begin
      po_exp_update <= 1'b0;
      po_done       <= 1'b0;
      case (state)
        S_IDLE, S_READY: begin
          if (accept) begin
            po_exp_key    <= pi_key;
            po_exp_round  <= '0;
            po_keys_valid <= 1'b0;
            po_busy       <= 1'b1;
            po_key_ready  <= 1'b0;
            po_exp_update <= 1'b1;
            state         <= S_STEP;
          end else begin
            po_key_ready <= 1'b1;
            // First READY cycle after the last capture publishes the schedule.
            if (state == S_READY && po_busy) begin
              po_done       <= 1'b1;
              po_keys_valid <= 1'b1;
              po_busy       <= 1'b0;
            end
          end
        end
        S_STEP: begin
          wait_cnt <= WAIT_INIT;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == '0) state <= S_CAPT;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        S_CAPT: begin
          store[po_exp_round] <= pi_exp_key;
          if (po_exp_round == LAST_RK) begin
            po_key_ready <= 1'b1;
            state        <= S_READY;
          end else begin
            po_exp_round  <= po_exp_round + 4'd1;
            po_exp_update <= 1'b1;
            state         <= S_STEP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Reads sample the registered po_keys_valid, so a read in the accept cycle still sees the old schedule.
  always_ff @(posedge pi_clk or posedge pi_rst) begin
    if (pi_rst) begin
      po_rk_valid <= 1'b0;
      po_rk_err   <= 1'b0;
      po_rk_data  <= '0;
    end else begin
      po_rk_valid <= 1'b0;
      po_rk_err   <= 1'b0;
      po_rk_data  <= '0;
      if (pi_rk_req) begin
        if (po_keys_valid && pi_rk_idx <= LAST_RK) begin
          po_rk_valid <= 1'b1;
          po_rk_data  <= store[pi_rk_idx];
        end else begin
          po_rk_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl: AES-128 expander model, read-port scoreboard, sequencing monitors,
// plus a second instance with EXP_LAT=3 for latency/spacing.
module tb_key_schedule_ctrl;
  localparam int EXP_LAT   = 2;
  localparam int DONE_LAT  = 11 * (EXP_LAT + 2) + 1;
  localparam int EXP_LAT3  = 3;
  localparam int DONE_LAT3 = 11 * (EXP_LAT3 + 2) + 1;

  logic         pi_clk, pi_rst;
  logic         pi_key_valid, po_key_ready;
  logic [127:0] pi_key, po_exp_key, pi_exp_key, po_rk_data;
  logic [3:0]   po_exp_round, pi_rk_idx;
  logic         po_exp_update, po_busy, po_done, po_keys_valid;
  logic         pi_rk_req, po_rk_valid, po_rk_err;
  logic [2:0]   po_dbg_state;

  logic         key3_valid, ready3, upd3, busy3, done3, kv3, rk_req3, rk_valid3, rk_err3;
  logic [127:0] key3, exp_key3, exp_in3, rk_data3;
  logic [3:0]   round3, rk_idx3;
  logic [2:0]   dbg3;

  logic [7:0]   sb [256];
  logic [127:0] model [11];
  bit           model_valid;
  logic [127:0] cur_key;
  logic [129:0] exp_q [$];
  int           done_q [$];
  int           cyc, total, bad, upd_cnt, last_upd;
  bit           dut3_fin;

  key_schedule_ctrl #(.EXP_LAT(EXP_LAT)) u_dut (
    .pi_clk(pi_clk), .pi_rst(pi_rst), .pi_key_valid(pi_key_valid), .pi_key(pi_key),
    .po_key_ready(po_key_ready), .po_exp_key(po_exp_key), .po_exp_round(po_exp_round),
    .po_exp_update(po_exp_update), .pi_exp_key(pi_exp_key), .po_busy(po_busy), .po_done(po_done),
    .po_keys_valid(po_keys_valid), .pi_rk_req(pi_rk_req), .pi_rk_idx(pi_rk_idx),
    .po_rk_valid(po_rk_valid), .po_rk_data(po_rk_data), .po_rk_err(po_rk_err),
    .po_dbg_state(po_dbg_state)
  );

  key_schedule_ctrl #(.EXP_LAT(EXP_LAT3)) u_dut3 (
    .pi_clk(pi_clk), .pi_rst(pi_rst), .pi_key_valid(key3_valid), .pi_key(key3),
    .po_key_ready(ready3), .po_exp_key(exp_key3), .po_exp_round(round3),
    .po_exp_update(upd3), .pi_exp_key(exp_in3), .po_busy(busy3), .po_done(done3),
    .po_keys_valid(kv3), .pi_rk_req(rk_req3), .pi_rk_idx(rk_idx3),
    .po_rk_valid(rk_valid3), .po_rk_data(rk_data3), .po_rk_err(rk_err3),
    .po_dbg_state(dbg3)
  );

  // clock / reset
  initial pi_clk = 1'b0;
  always #5 pi_clk = ~pi_clk;
  always @(posedge pi_clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [129:0] act, logic [129:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // AES-128 reference: GF(2^8) arithmetic, S-box table, FIPS-197 key expansion
  function automatic logic [7:0] xt(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] a, int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  initial begin
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  function automatic logic [127:0] round_key(logic [127:0] key, int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Expander model: junk right after the strobe, the true round key EXP_LAT cycles later.
  initial begin
    int r;
    logic [127:0] k;
    pi_exp_key = '0;
    forever begin
      @(negedge pi_clk);
      if (!pi_rst && po_exp_update) begin
        r = int'(po_exp_round);
        k = po_exp_key;
        pi_exp_key = {$urandom, $urandom, $urandom, $urandom};
        repeat (EXP_LAT) @(posedge pi_clk);
        #1 pi_exp_key = round_key(k, r);
      end
    end
  end

  function automatic logic [129:0] exp_rd(logic [3:0] idx);
    if (model_valid && idx <= 4'd10) return {2'b10, model[idx]};
    return {2'b01, 128'h0};
  endfunction

  // driver tasks (called at a negedge, return at a negedge)
  task automatic rd(input logic [3:0] idx);
    pi_rk_req = 1'b1;
    pi_rk_idx = idx;
    exp_q.push_back(exp_rd(idx));
    @(negedge pi_clk);
    pi_rk_req = 1'b0;
  endtask

  task automatic rand_reads(input int n);
    for (int i = 0; i < n; i++) begin
      rd(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) @(negedge pi_clk);
    end
  endtask

  task automatic load_key(input logic [127:0] k, input bit rd_acc);
    int n;
    n = 0;
    pi_key = k;
    pi_key_valid = 1'b1;
    while (!po_key_ready && n < 100) begin
      @(negedge pi_clk);
      n++;
    end
    chk("acc_ready", po_key_ready, 1);
    if (rd_acc) begin
      pi_rk_req = 1'b1;
      pi_rk_idx = 4'd10;
      exp_q.push_back(exp_rd(4'd10));
    end
    @(posedge pi_clk);
    #1;
    done_q.push_back(cyc + DONE_LAT);
    model_valid = 1'b0;
    cur_key = k;
    pi_key_valid = 1'b0;
    pi_rk_req = 1'b0;
    @(negedge pi_clk);
    chk("acc_state", {po_busy, po_keys_valid, po_key_ready}, 3'b100);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!po_done && n < 300) begin
      @(negedge pi_clk);
      n++;
    end
    chk("done_seen", po_done, 1);
    chk("done_kv", {po_keys_valid, po_busy}, 2'b10);
    model_valid = 1'b1;
    for (int r = 0; r < 11; r++) model[r] = round_key(cur_key, r);
  endtask

  task automatic async_reset();
    @(posedge pi_clk);
    #3 pi_rst = 1'b1;
    #1;
    chk("rst_ctl", {po_key_ready, po_busy, po_done, po_keys_valid, po_exp_update, po_exp_round,
                    po_rk_valid, po_rk_err, po_dbg_state}, '0);
    chk("rst_key", po_exp_key, 0);
    chk("rst_rd", po_rk_data, 0);
    model_valid = 1'b0;
    done_q.delete();
    exp_q.delete();
    repeat (2) @(negedge pi_clk);
    pi_rst = 1'b0;
    #1 chk("rel_ready0", po_key_ready, 0);
    @(posedge pi_clk);
    #1 chk("rel_ready1", po_key_ready, 1);
    @(negedge pi_clk);
  endtask

  // scoreboard monitor for the read port
  always @(negedge pi_clk) begin
    if (!pi_rst) begin
      if (po_rk_valid || po_rk_err) begin
        if (exp_q.size() == 0) chk("rd_unexpected", {po_rk_valid, po_rk_err, po_rk_data}, 0);
        else chk("rd_resp", {po_rk_valid, po_rk_err, po_rk_data}, exp_q.pop_front());
      end else begin
        chk("rd_idle_data", po_rk_data, 0);
      end
    end
  end

  // sequencing monitor: update strobes and done timing
  always @(negedge pi_clk) begin
    if (pi_rst) begin
      upd_cnt = 0;
    end else begin
      if (po_exp_update) begin
        chk("upd_round", po_exp_round, upd_cnt);
        if (upd_cnt > 0) chk("upd_gap", cyc - last_upd, EXP_LAT + 2);
        last_upd = cyc;
        upd_cnt++;
      end
      if (po_done) begin
        chk("done_upds", upd_cnt, 11);
        upd_cnt = 0;
        if (done_q.size() == 0) chk("done_spurious", 1, 0);
        else chk("done_lat", cyc, done_q.pop_front());
      end
    end
  end

  // EXP_LAT=3 instance: latency and strobe spacing only
  initial begin
    int n, c3, acc3, lu;
    key3_valid = 1'b0; key3 = '0; exp_in3 = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    rk_req3 = 1'b0; rk_idx3 = '0; dut3_fin = 1'b0;
    repeat (6) @(negedge pi_clk);
    key3 = {$urandom, $urandom, $urandom, $urandom};
    key3_valid = 1'b1;
    n = 0;
    while (!ready3 && n < 50) begin
      @(negedge pi_clk);
      n++;
    end
    chk("u3_ready", ready3, 1);
    @(posedge pi_clk);
    #1;
    acc3 = cyc; key3_valid = 1'b0; c3 = 0; n = 0; lu = 0;
    while (n < 200) begin
      @(negedge pi_clk);
      n++;
      if (upd3) begin
        chk("u3_round", round3, c3);
        if (c3 > 0) chk("u3_gap", cyc - lu, EXP_LAT3 + 2);
        lu = cyc;
        c3++;
      end
      if (done3) break;
    end
    chk("u3_done_lat", cyc - acc3, DONE_LAT3);
    chk("u3_upds", c3, 11);
    dut3_fin = 1'b1;
  end

  // main stimulus
  initial begin
    int n;
    pi_rst = 1'b1; pi_key_valid = 1'b0; pi_key = '0; pi_rk_req = 1'b0; pi_rk_idx = '0;
    model_valid = 1'b0; cur_key = '0;
    repeat (3) @(negedge pi_clk);
    chk("rst_hold", {po_key_ready, po_busy, po_done, po_keys_valid, po_exp_update, po_exp_round,
                     po_rk_valid, po_rk_err, po_dbg_state}, '0);
    chk("rst_hold_key", po_exp_key, 0);
    pi_rst = 1'b0;
    #1 chk("init_ready0", po_key_ready, 0);
    @(posedge pi_clk);
    #1 chk("init_ready1", po_key_ready, 1);
    @(negedge pi_clk);
    rd(4'd4);
    rd(4'd11);

    // FIPS-197 known-answer key
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
    rd(4'd2);
    wait_done();
    chk("kat_idx0", model[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("kat_idx1", model[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("kat_idx10", model[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd(4'd0); rd(4'd5); rd(4'd10);
    rd(4'd11); rd(4'd15);
    rand_reads(12);

    // rekey from READY with a read in the accept cycle, then a stale offer held while busy
    load_key(128'h000102030405060708090a0b0c0d0e0f, 1'b1);
    pi_key = {$urandom, $urandom, $urandom, $urandom};
    pi_key_valid = 1'b1;
    repeat (20) @(negedge pi_clk);
    chk("busy_ready", {po_key_ready, po_busy}, 2'b01);
    pi_key_valid = 1'b0;
    wait_done();
    chk("kat2_idx10", model[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("exp_key_hold", po_exp_key, 128'h000102030405060708090a0b0c0d0e0f);
    rd(4'd10);
    rand_reads(10);

    // random keys
    for (int k = 0; k < 2; k++) begin
      load_key({$urandom, $urandom, $urandom, $urandom}, 1'b0);
      rd(4'($urandom_range(0, 15)));
      wait_done();
      rand_reads(14);
    end

    // reset at round 6, then a fresh key
    load_key({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    n = 0;
    while (po_exp_round != 4'd6 && n < 100) begin
      @(negedge pi_clk);
      n++;
    end
    chk("r6_reached", po_exp_round, 6);
    async_reset();
    rd(4'd0);
    repeat (60) @(negedge pi_clk);
    load_key({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    wait_done();
    rd(4'd0); rd(4'd6); rd(4'd10);
    rand_reads(8);

    repeat (3) @(negedge pi_clk);
    chk("rd_q_empty", exp_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    n = 0;
    while (!dut3_fin && n < 500) begin
      @(negedge pi_clk);
      n++;
    end
    chk("dut3_fin", dut3_fin, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
